// File: rtl/rcc_scan_pkg.sv
// Shared constants and register-map helpers for the RCC scan-inc status block.
// Word indices are derived from the channel count so that every instance shares one map layout.
package rcc_scan_pkg;

    function automatic int nword(input int nch, input int dw);
        return (nch + dw - 1) / dw;
    endfunction

    function automatic int stat_base();
        return 0;
    endfunction

    function automatic int mask_base(input int nw);
        return nw;
    endfunction

    function automatic int cnt_idx(input int nw);
        return 2 * nw;
    endfunction

    // vcore channel set: qspi sits at the top, pll_src_clk at bit 0.
    localparam int VCORE_NCH      = 30;
    localparam int CH_QSPI        = 29;
    localparam int CH_PLL_SRC_CLK = 0;

endpackage

// File: rtl/rcc_scan_sync.sv
// Per-channel synchroniser chain followed by an edge register.
// A rise is reported for one cycle when the synchronised level goes 0 -> 1.
module rcc_scan_sync
    import rcc_scan_pkg::*;
#(
    parameter int NCH         = 30,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] din,
    output logic [NCH-1:0] rise
);

    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // prev_q resets low, so a level already high out of reset still produces one rise.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rcc_scan_inc_stat.sv
// Scan-inc status block: sticky W1C status, per-channel mask, saturating event counter
// and a registered read path that ORs the selected word into the upstream RCC read data.
module rcc_scan_inc_stat
    import rcc_scan_pkg::*;
#(
    parameter int DW          = 32,
    parameter int NCH         = 30,
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 16,
    parameter int IW          = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] scan_inc,
    input  logic [IW-1:0]  reg_idx,
    input  logic           rd_en,
    input  logic           wr_en,
    input  logic [DW-1:0]  wr_data,
    input  logic [DW-1:0]  mdata,
    output logic [DW-1:0]  wdata,
    output logic           rd_vld,
    output logic           irq
);

    localparam int              NWORD    = nword(NCH, DW);
    localparam int              PW       = NWORD * DW;
    localparam logic [PW-1:0]   CH_VALID = PW'({NCH{1'b1}});
    localparam logic [CW-1:0]   CNT_MAX  = '1;

    logic [NCH-1:0]   rise;
    logic [PW-1:0]    stat, stat_next;
    logic [PW-1:0]    mask, mask_next, mask_wr_val;
    logic [PW-1:0]    w1c;
    logic [NWORD-1:0] stat_wr, mask_wr;
    logic             cnt_clr, cnt_inc;
    logic [CW-1:0]    cnt, cnt_next;
    logic [DW-1:0]    rd_word, rd_q;

    rcc_scan_sync #(
        .NCH         (NCH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (scan_inc),
        .rise  (rise)
    );

    for (genvar k = 0; k < NWORD; k++) begin : g_word
        assign stat_wr[k] = wr_en && (reg_idx == IW'(stat_base() + k));
        assign mask_wr[k] = wr_en && (reg_idx == IW'(mask_base(NWORD) + k));
        assign w1c[k*DW +: DW]         = stat_wr[k] ? wr_data : '0;
        assign mask_wr_val[k*DW +: DW] = mask_wr[k] ? wr_data : mask[k*DW +: DW];
    end

    // Bits above NCH are held at zero so the last word reads back clean.
    assign stat_next = ((stat & ~w1c) | PW'(rise)) & CH_VALID;
    assign mask_next = mask_wr_val & CH_VALID;

    assign cnt_clr = wr_en && (reg_idx == IW'(cnt_idx(NWORD)));
    assign cnt_inc = |(PW'(rise) & mask);

    // Clear first, then count: a clear coinciding with an event leaves cnt at 1.
    always_comb begin
        cnt_next = cnt_clr ? '0 : cnt;
        if (cnt_inc && (cnt_next != CNT_MAX)) cnt_next = cnt_next + CW'(1);
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NWORD; k++) begin
            if (reg_idx == IW'(stat_base() + k))      rd_word = stat[k*DW +: DW];
            if (reg_idx == IW'(mask_base(NWORD) + k)) rd_word = mask[k*DW +: DW];
        end
        if (reg_idx == IW'(cnt_idx(NWORD))) rd_word = DW'(cnt);
    end

    // Read handshake: rd_en in cycle t (no backpressure) -> rd_vld=1 and wdata carries the
    // pre-write word in cycle t+1; rd_vld is 0 in every cycle not following a read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat   <= '0;
            mask   <= '0;
            cnt    <= '0;
            irq    <= 1'b0;
            rd_q   <= '0;
            rd_vld <= 1'b0;
        end else begin
            stat   <= stat_next;
            mask   <= mask_next;
            cnt    <= cnt_next;
            irq    <= |(stat_next & mask_next);
            rd_vld <= rd_en;
            if (rd_en) rd_q <= rd_word;
        end
    end

    assign wdata = rd_vld ? (mdata | rd_q) : mdata;

endmodule

// File: tb/tb_rcc_scan_inc_stat.sv
// Directed bench for rcc_scan_inc_stat: a default 30-channel instance and a 40-channel
// instance share the register bus; each step checks hand-computed read words and irq.
module tb_rcc_scan_inc_stat;

    logic        clk;
    logic        rst_n;
    logic [29:0] scan0;
    logic [39:0] scan1;
    logic [3:0]  reg_idx;
    logic        rd_en, wr_en;
    logic [31:0] wr_data, mdata;
    logic [31:0] wdata0, wdata1;
    logic        rd_vld0, rd_vld1, irq0, irq1;

    int n_cmp = 0;
    int n_err = 0;

    rcc_scan_inc_stat #(.DW(32), .NCH(30), .SYNC_STAGES(2), .CW(16), .IW(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .scan_inc(scan0), .reg_idx(reg_idx),
        .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data), .mdata(mdata),
        .wdata(wdata0), .rd_vld(rd_vld0), .irq(irq0)
    );

    rcc_scan_inc_stat #(.DW(32), .NCH(40), .SYNC_STAGES(2), .CW(16), .IW(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .scan_inc(scan1), .reg_idx(reg_idx),
        .rd_en(rd_en), .wr_en(wr_en), .wr_data(wr_data), .mdata(mdata),
        .wdata(wdata1), .rd_vld(rd_vld1), .irq(irq1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [31:0] data);
        reg_idx = idx;
        wr_data = data;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic do_read(input int inst, input logic [3:0] idx, input logic [31:0] md,
                           input logic [31:0] exp_word, input string tag);
        reg_idx = idx;
        mdata   = md;
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
        chk({tag, "_vld"}, (inst == 1) ? 32'(rd_vld1) : 32'(rd_vld0), 32'd1);
        chk(tag, (inst == 1) ? wdata1 : wdata0, md | exp_word);
        tick();
        chk({tag, "_idle"}, (inst == 1) ? 32'(rd_vld1) : 32'(rd_vld0), 32'd0);
        chk({tag, "_pass"}, (inst == 1) ? wdata1 : wdata0, md);
    endtask

    initial begin
        rst_n   = 1'b0;
        scan0   = '0;
        scan1   = '0;
        reg_idx = '0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        mdata   = '0;
        repeat (3) tick();
        chk("rst_irq0", 32'(irq0), 32'd0);
        chk("rst_vld0", 32'(rd_vld0), 32'd0);
        chk("rst_wdata0", wdata0, 32'd0);
        chk("rst_irq1", 32'(irq1), 32'd0);
        rst_n = 1'b1;
        tick();

        // reset contents of STAT, MASK, CNT
        do_read(0, 4'd0, 32'h1234_5678, 32'h0, "rd_stat_rst");
        do_read(0, 4'd1, 32'hA5A5_0000, 32'h0, "rd_mask_rst");
        do_read(0, 4'd2, 32'h0000_00FF, 32'h0, "rd_cnt_rst");
        chk("irq_after_rst_reads", 32'(irq0), 32'd0);

        // one-cycle pulse on ch5: stat visible exactly 3 edges after the change
        scan0[5] = 1'b1;
        tick();
        scan0[5] = 1'b0;
        tick();
        reg_idx = 4'd0;
        mdata   = 32'h0;
        rd_en   = 1'b1;
        tick();
        chk("stat5_early", wdata0, 32'h0);
        tick();
        chk("stat5_latency", wdata0, 32'h20);
        rd_en = 1'b0;

        // second rise while set changes nothing; merged read ORs with mdata
        scan0[5] = 1'b1;
        repeat (4) tick();
        do_read(0, 4'd0, 32'h8000_0000, 32'h20, "stat5_merge");
        do_read(0, 4'd2, 32'h0, 32'h0, "cnt_unmasked");
        chk("irq_unmasked", 32'(irq0), 32'd0);

        // mask raises irq, W1C drops it
        do_write(4'd1, 32'h20);
        chk("irq_masked_on", 32'(irq0), 32'd1);
        do_write(4'd0, 32'h20);
        chk("irq_w1c_off", 32'(irq0), 32'd0);
        do_read(0, 4'd0, 32'h0, 32'h0, "stat5_cleared");

        // rise on ch7 with same-cycle W1C, ch7 unmasked: set wins, no count
        scan0[7] = 1'b1;
        tick();
        tick();
        do_write(4'd0, 32'h80);
        do_read(0, 4'd0, 32'h0, 32'h80, "stat7_set_wins");
        do_read(0, 4'd2, 32'h0, 32'h0, "cnt7_unmasked");
        chk("irq7_unmasked", 32'(irq0), 32'd0);

        // same again with ch7 masked in: set wins and cnt counts
        do_write(4'd1, 32'hA0);
        chk("irq7_masked", 32'(irq0), 32'd1);
        scan0[7] = 1'b0;
        repeat (4) tick();
        scan0[7] = 1'b1;
        tick();
        tick();
        do_write(4'd0, 32'h80);
        chk("irq7_still", 32'(irq0), 32'd1);
        do_read(0, 4'd2, 32'h0, 32'h1, "cnt7_masked");

        // all-ones mask: unused upper bits read 0; multi-bit rise counts once
        do_write(4'd1, 32'hFFFF_FFFF);
        do_read(0, 4'd1, 32'h0, 32'h3FFF_FFFF, "mask_all");
        do_write(4'd0, 32'hFFFF_FFFF);
        chk("irq_all_clear", 32'(irq0), 32'd0);
        scan0 = scan0 | 30'h209;
        repeat (3) tick();
        do_read(0, 4'd0, 32'h0, 32'h209, "stat_multi");
        do_read(0, 4'd2, 32'h0, 32'h2, "cnt_multi");
        chk("irq_multi", 32'(irq0), 32'd1);

        // saturation: a masked rise every cycle for more than 2^16 cycles
        scan0 = '0;
        repeat (4) tick();
        for (int i = 0; i < 65600; i++) begin
            scan0 = i[0] ? 30'h2AAA_AAAA : 30'h1555_5555;
            tick();
        end
        scan0 = '0;
        repeat (4) tick();
        do_read(0, 4'd2, 32'h0, 32'h0000_FFFF, "cnt_sat");
        do_read(0, 4'd0, 32'h0, 32'h3FFF_FFFF, "stat_sat");

        // counter clear coinciding with an event gives 1; plain clear gives 0
        scan0 = 30'h2;
        tick();
        tick();
        do_write(4'd2, 32'h0);
        do_read(0, 4'd2, 32'h0, 32'h1, "cnt_clr_inc");
        do_write(4'd2, 32'hFFFF);
        do_read(0, 4'd2, 32'h0, 32'h0, "cnt_clr");

        // masking off the pending bits drops irq
        do_write(4'd1, 32'h0);
        chk("irq_mask_off", 32'(irq0), 32'd0);

        // asynchronous reset mid-read with irq high
        do_write(4'd1, 32'h1);
        chk("irq_pre_rst", 32'(irq0), 32'd1);
        reg_idx = 4'd0;
        mdata   = 32'h0;
        rd_en   = 1'b1;
        tick();
        chk("vld_pre_rst", 32'(rd_vld0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wdata0", wdata0, 32'h0);
        chk("arst_vld0", 32'(rd_vld0), 32'd0);
        chk("arst_irq0", 32'(irq0), 32'd0);
        chk("arst_wdata1", wdata1, 32'h0);
        chk("arst_vld1", 32'(rd_vld1), 32'd0);
        chk("arst_irq1", 32'(irq1), 32'd0);
        rd_en = 1'b0;
        scan0 = 30'h4;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        do_read(0, 4'd0, 32'h0, 32'h4, "fresh_edge");
        do_read(0, 4'd1, 32'h0, 32'h0, "mask_after_rst");
        do_read(0, 4'd2, 32'h0, 32'h0, "cnt_after_rst");

        // 40-channel instance: ch35 lands in word1 bit3
        scan1[35] = 1'b1;
        repeat (4) tick();
        do_read(1, 4'd1, 32'h0, 32'h8, "u1_stat_w1");
        do_read(1, 4'd0, 32'h0, 32'h0, "u1_stat_w0");
        do_write(4'd3, 32'hFFFF_FFFF);
        chk("u1_irq_on", 32'(irq1), 32'd1);
        do_read(1, 4'd3, 32'h0, 32'h0000_00FF, "u1_mask_w1");
        do_read(1, 4'd2, 32'h0, 32'h0, "u1_mask_w0");
        do_read(1, 4'd4, 32'h0, 32'h0, "u1_cnt");

        // simultaneous read and W1C to the same word: old value returned, write applied
        reg_idx = 4'd1;
        mdata   = 32'h0;
        wr_data = 32'h8;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        chk("u1_rdwr_old", wdata1, 32'h8);
        chk("u1_irq_off", 32'(irq1), 32'd0);
        tick();
        do_read(1, 4'd1, 32'h0, 32'h0, "u1_rdwr_new");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
